gpio_seg7_display: RTL and testbench
====================================

# gpio_seg7_display

Downstream consumer of the CPU's `GPIO_out` register: converts the 32-bit unsigned value the CPU writes via `csrrw` into decimal and drives the board's eight active-low seven-segment digits. Conversion is a sequential double-dabble (shift-and-add-3) engine, one bit per cycle. The displayed value always converges to the latest `GPIO_out` value. Instantiated in the board top level between `CPU.GPIO_out` and the `HEX` pins.

## Interface
Parameters:
- `WIDTH`, 32: binary input width.
- `DIGITS`, 8: number of physical seven-segment digits driven; must be ≤ `BCD_DIGITS`.
- `BCD_DIGITS` (localparam) = (WIDTH*3)/10+1: internal BCD digit count (10 for WIDTH=32).

Ports (one clock, `clk`; reset `rst_n` is asynchronous, active-low):
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `value_in`  in  WIDTH  unsigned value, wired to `GPIO_out`.
- `seg_n`  out  7*DIGITS  segment drive, digit k at bits [7k+6:7k], order gfedcba, active-low.
- `overflow`  out  1  high when any BCD digit at index ≥ DIGITS is nonzero.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse when `seg_n`/`overflow` update.

## Operation
- Registers: `last_value` (WIDTH), `bin_sr` (WIDTH), `bcd_sr` (4*BCD_DIGITS), `bit_cnt` (clog2(WIDTH)), state, output registers.
- States: IDLE, SHIFT, DONE.
- IDLE: on an edge where `value_in != last_value`, load `bin_sr` and `last_value` from `value_in`, clear `bcd_sr` and `bit_cnt`, go to SHIFT. Otherwise remain in IDLE.
- SHIFT, each edge:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift {`bcd_sr`,`bin_sr`} left by 1.
  - Increment `bit_cnt`.
  - After the edge where `bit_cnt == WIDTH-1`, go to DONE.
- DONE, one edge:
  - Register `seg_n` from BCD digits 0..DIGITS-1 through the decoder, with leading-zero blanking. Digit 0 is always shown; a digit k>0 is blank (7'h7F) if it and all higher displayed digits are zero.
  - Register `overflow`.
  - Pulse `done`.
  - Go to IDLE.
- Digit codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex). Nibbles >9 never occur; the decoder maps them to blank.
- `value_in` changes during SHIFT/DONE are ignored. Because `last_value` still holds the old value, a new conversion starts on the first edge back in IDLE, so the final display always matches the final input.
- Reset values:
  - State IDLE, `last_value`=0, `bin_sr`=0, `bcd_sr`=0, `bit_cnt`=0.
  - `seg_n`: digit 0 = 7'h40, all others 7'h7F.
  - `overflow`=0, `busy`=0, `done`=0.
- Reset mid-conversion aborts immediately. Outputs return to reset values. If `value_in` is nonzero, conversion starts on the first edge after deassertion.

## Timing
- Capture edge E0 = first edge with `value_in != last_value` in IDLE.
- SHIFT occupies edges E1..E_WIDTH (32 edges).
- DONE is edge E_WIDTH+1 (E33). `seg_n`/`overflow` change and `done`=1 after E33.
- `done` falls after E34.
- `busy` = (state != IDLE), registered: high after E0, low after E33.
- Back-to-back conversions: earliest next capture is E34, giving a 34-cycle period.
- `value_in` is sampled only at E0 and need not be held afterwards.
- No combinational path from `value_in` to any output.

## Structure
- Package `display_pkg`:
  - State enum `disp_state_t` {IDLE, SHIFT, DONE}.
  - Constants `SEG_BLANK`=7'h7F and `SEG_DIGIT[0:9]` array.
  - Function `bcd_add3(nibble)`.
- Sub-module `seg7_decoder`: combinational 4-bit → 7-bit active-low lookup with `blank` input, one instance per displayed digit (generate loop).
- The top `gpio_seg7_display` holds the FSM, shift registers, counter, blanking logic and output registers.

## Test plan
- Reset, `value_in`=0 for 50 cycles → digit0=7'h40, digits1–7=7'h7F, `busy`=0, `done` never pulses.
- `value_in`=32'd29 applied before edge E0 → `busy`=1 after E0; after E33: digit0=7'h10, digit1=7'h24, digits2–7 blank, `overflow`=0, `done` high exactly one cycle.
- `value_in`=32'hDBEEF000 (3,689,869,312) → after 33 edges: digits0–7 = 2,1,3,9,6,8,9,8 (7'h24,79,30,10,02,00,10,00), `overflow`=1.
- `value_in`=29, then `value_in`=3 at E5 (mid-SHIFT) → first `done` shows 29. Second capture at E34, second `done` after E67 shows digit0=7'h30 with all others blank. Exactly two `done` pulses.
- Start conversion of 29, assert `rst_n`=0 at E10 asynchronously (between edges) → outputs are at reset values immediately. Release with `value_in`=3 → capture on first edge after release, display 3 after 33 more edges.
- `value_in`=32'd10000000 → digits0–6 = 7'h40, digit7 = 7'h79, `overflow`=0. Then 32'd99999999 → all digits 7'h10, `overflow`=0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types, segment codes and BCD helper for the seven-segment display path.
package display_pkg;

  // Conversion FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } disp_state_t;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Double-dabble correction: nibbles of 5 or more get 3 added before the shift
  function automatic logic [3:0] bcd_add3(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low seven-segment lookup with blanking.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_n_o
);

  // Lookup; blanked digits and non-decimal nibbles drive all segments off
  always_comb begin
    seg_n_o = SEG_BLANK;
    if (!blank_i) begin
      for (int unsigned i = 0; i < 10; i++) begin
        if (digit_i == 4'(i)) seg_n_o = SEG_DIGIT[i];
      end
    end
  end

endmodule

// File: rtl/gpio_seg7_display.sv
// Converts the CPU GPIO output value to decimal with a bit-serial double-dabble
// engine and drives eight active-low seven-segment digits with leading-zero
// blanking. The display always converges to the most recent input value.
module gpio_seg7_display
  import display_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      value_in,
  output logic [7*DIGITS-1:0]   seg_n,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done
);

  localparam int BCD_DIGITS = (WIDTH * 3) / 10 + 1;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Reset display: digit 0 shows '0', every other digit blank
  function automatic logic [7*DIGITS-1:0] seg_reset_value();
    logic [7*DIGITS-1:0] v;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      v[7*k +: 7] = (k == 0) ? SEG_DIGIT[0] : SEG_BLANK;
    end
    return v;
  endfunction

  localparam logic [7*DIGITS-1:0] SEG_RESET = seg_reset_value();

  disp_state_t          state_q;
  logic [WIDTH-1:0]     last_value_q;
  logic [WIDTH-1:0]     bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]     bcd_sr_q, bcd_sr_d;
  logic [BCD_W-1:0]     bcd_adj;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [7*DIGITS-1:0]  seg_q;
  logic [7*DIGITS-1:0]  seg_dec;
  logic                 overflow_q, overflow_d;
  logic                 busy_q;
  logic                 done_q;
  logic [DIGITS-1:0]    blank;

  // One double-dabble step: correct every nibble, then shift BCD:binary left
  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      bcd_adj[4*i +: 4] = bcd_add3(bcd_sr_q[4*i +: 4]);
    end
    {bcd_sr_d, bin_sr_d} = {bcd_adj, bin_sr_q} << 1;
  end

  // Leading-zero blanking: scan from the top digit down, blank until a nonzero digit
  always_comb begin
    logic nz;
    nz    = 1'b0;
    blank = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nz = nz | (bcd_sr_q[4*(DIGITS-1-i) +: 4] != 4'd0);
      blank[DIGITS-1-i] = ((DIGITS - 1 - i) != 0) && !nz;
    end
  end

  // Overflow: any BCD digit beyond the physical display is nonzero
  always_comb begin
    overflow_d = 1'b0;
    for (int unsigned i = DIGITS; i < BCD_DIGITS; i++) begin
      overflow_d = overflow_d | (bcd_sr_q[4*i +: 4] != 4'd0);
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dec
      seg7_decoder u_dec (
        .digit_i (bcd_sr_q[4*g +: 4]),
        .blank_i (blank[g]),
        .seg_n_o (seg_dec[7*g +: 7])
      );
    end
  endgenerate

  // Conversion FSM with registered display, overflow, busy and done outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_value_q <= '0;
      bin_sr_q     <= '0;
      bcd_sr_q     <= '0;
      bit_cnt_q    <= '0;
      seg_q        <= SEG_RESET;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (value_in != last_value_q) begin
            last_value_q <= value_in;
            bin_sr_q     <= value_in;
            bcd_sr_q     <= '0;
            bit_cnt_q    <= '0;
            busy_q       <= 1'b1;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_sr_q  <= bcd_sr_d;
          bin_sr_q  <= bin_sr_d;
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_LAST) state_q <= DONE;
        end
        DONE: begin
          seg_q      <= seg_dec;
          overflow_q <= overflow_d;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign seg_n    = seg_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_gpio_seg7_display.sv
// Scoreboard bench for gpio_seg7_display: expected displays are computed from a
// decimal model when a value is driven, and compared whenever done pulses.
module tb_gpio_seg7_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] value_in;
  logic [55:0] seg_n;
  logic        overflow, busy, done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [55:0] seg;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  logic [6:0] code_tbl [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  localparam logic [55:0] SEG_RST = {{7{7'h7F}}, 7'h40};

  always #5 clk = ~clk;

  gpio_seg7_display #(.WIDTH(32), .DIGITS(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value_in (value_in),
    .seg_n    (seg_n),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference: split into ten digits, blank leading zeros of the 8 shown
  function automatic exp_t model(input logic [31:0] v);
    exp_t e;
    longint unsigned x;
    logic [3:0] dig [0:9];
    logic nz;
    x = v;
    for (int i = 0; i < 10; i++) begin
      dig[i] = 4'(x % 10);
      x = x / 10;
    end
    nz = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      nz = nz | (dig[k] != 0);
      e.seg[7*k +: 7] = (k != 0 && !nz) ? 7'h7F : code_tbl[dig[k]];
    end
    e.ovf = (dig[8] != 0) || (dig[9] != 0);
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_seg", 64'(seg_n), 64'(e.seg));
        chk("sb_ovf", 64'(overflow), 64'(e.ovf));
        chk("sb_busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Count edges until done is seen (sampled 1ns after each edge)
  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // Full conversion with latency and pulse-width checks
  task automatic conv(input logic [31:0] v, input string tag);
    int lat;
    @(negedge clk);
    value_in = v;
    sb.push_back(model(v));
    @(posedge clk); #1;
    chk({tag, "_busy_E0"}, 64'(busy), 64'd1);
    wait_done(40, lat);
    chk({tag, "_latency"}, 64'(lat), 64'd33);
    @(posedge clk); #1;
    chk({tag, "_done_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    int base;
    logic [31:0] r;

    // Reset and idle with zero input
    rst_n = 1'b0;
    value_in = '0;
    #12;
    chk("rst_seg", 64'(seg_n), 64'(SEG_RST));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("idle_seg", 64'(seg_n), 64'(SEG_RST));
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_no_done", 64'(done_cnt), 64'd0);

    // 29
    conv(32'd29, "v29");
    chk("v29_seg", 64'(seg_n), 64'({{6{7'h7F}}, 7'h24, 7'h10}));
    chk("v29_ovf", 64'(overflow), 64'd0);

    // Ten-digit value with overflow
    conv(32'hDBEEF000, "vbeef");
    chk("vbeef_seg", 64'(seg_n),
        64'({7'h00, 7'h10, 7'h00, 7'h02, 7'h10, 7'h30, 7'h79, 7'h24}));
    chk("vbeef_ovf", 64'(overflow), 64'd1);

    // Input change mid-SHIFT: 29 finishes, then 3 is picked up at E34
    base = done_cnt;
    @(negedge clk);
    value_in = 32'd29;
    sb.push_back(model(32'd29));
    sb.push_back(model(32'd3));
    @(posedge clk);                 // E0
    repeat (4) @(posedge clk);      // E1..E4
    #1 value_in = 32'd3;            // seen only after the first conversion
    wait_done(40, lat);
    chk("mid_first_latency", 64'(lat + 4), 64'd33);
    chk("mid_first_seg", 64'(seg_n), 64'({{6{7'h7F}}, 7'h24, 7'h10}));
    wait_done(40, lat);
    chk("mid_second_latency", 64'(lat + 33), 64'd67);
    chk("mid_second_seg", 64'(seg_n), 64'({{7{7'h7F}}, 7'h30}));
    repeat (40) @(posedge clk);
    #1;
    chk("mid_two_dones", 64'(done_cnt - base), 64'd2);

    // Asynchronous reset in the middle of a conversion
    @(negedge clk);
    value_in = 32'd29;
    @(posedge clk);                 // E0
    repeat (9) @(posedge clk);      // E1..E9
    #2 rst_n = 1'b0;
    value_in = 32'd3;
    #1;
    chk("arst_seg", 64'(seg_n), 64'(SEG_RST));
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    sb.push_back(model(32'd3));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_capture", 64'(busy), 64'd1);
    wait_done(40, lat);
    chk("arst_latency", 64'(lat), 64'd33);
    chk("arst_seg3", 64'(seg_n), 64'({{7{7'h7F}}, 7'h30}));

    // Zeros inside a full-width number, and the largest 8-digit value
    conv(32'd10000000, "v1e7");
    chk("v1e7_seg", 64'(seg_n), 64'({7'h79, {7{7'h40}}}));
    chk("v1e7_ovf", 64'(overflow), 64'd0);
    conv(32'd99999999, "v9s");
    chk("v9s_seg", 64'(seg_n), 64'({8{7'h10}}));
    chk("v9s_ovf", 64'(overflow), 64'd0);

    // Exactly 10^8: every shown digit zero, only digit 0 lit
    conv(32'd100000000, "v1e8");
    chk("v1e8_seg", 64'(seg_n), 64'(SEG_RST));
    chk("v1e8_ovf", 64'(overflow), 64'd1);

    // Back to zero, max, then a few random values through the scoreboard
    conv(32'd0, "vzero");
    conv(32'hFFFFFFFF, "vmax");
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      if (i[0]) r = r % 32'd100000;
      if (r == value_in) r = r ^ 32'd1;
      conv(r, "vrand");
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
